// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite compositor.
//   - pal_idx_t / rgb_t: palette index and 24-bit colour types
//   - PALETTE: the eight-entry colour table, with pal_lookup() as accessor
//   - dir_e: tank orientation (clockwise rotation of the sprite)
//   - flash_state_e: per-tank hit-flash states
package sprite_pkg;

    localparam int PAL_ENTRIES = 8;

    typedef logic [2:0]  pal_idx_t;
    typedef logic [23:0] rgb_t;

    localparam rgb_t RGB_BLACK = 24'h000000;

    localparam rgb_t PALETTE [PAL_ENTRIES] = '{
        24'hFF3131, 24'h312D2B, 24'h878685, 24'h9B9DA0,
        24'hFFE100, 24'hFF00D6, 24'h000000, 24'hFFFFFF
    };

    typedef enum logic [1:0] {
        DIR_0   = 2'd0,
        DIR_90  = 2'd1,
        DIR_180 = 2'd2,
        DIR_270 = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLASH = 2'd1,
        DEAD  = 2'd2
    } flash_state_e;

    function automatic rgb_t pal_lookup(input pal_idx_t idx);
        return PALETTE[idx];
    endfunction

endpackage

// File: rtl/sprite_compositor_flash.sv
// Per-tank hit-flash state machine.
// Ports:
//   CLK         pixel clock
//   Reset       synchronous, active-high
//   frame_start one-cycle pulse per frame; advances the blink counter
//   tank_shot   level, tank has been hit; its rising edge starts the flash,
//               low returns the tank to IDLE (respawn)
//   visible     combinational view of whether the tank should be drawn
module tank_flash_fsm
    import sprite_pkg::*;
#(
    parameter int FLASH_FRAMES = 30
) (
    input  logic CLK,
    input  logic Reset,
    input  logic frame_start,
    input  logic tank_shot,
    output logic visible
);

    localparam int CNT_W = $clog2(FLASH_FRAMES + 1);

    flash_state_e     r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic             r_shot_d;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_shot_d <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_shot_d <= tank_shot;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        visible      = 1'b0;

        // Respawn (shot released) outranks everything, including frame_start.
        if (!tank_shot) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    // Loading on the edge also swallows a coincident frame_start.
                    if (!r_shot_d) begin
                        w_state_next = FLASH;
                        w_cnt_next   = CNT_W'(FLASH_FRAMES);
                    end
                end
                FLASH: begin
                    if (frame_start) begin
                        if (r_cnt == CNT_W'(1)) begin
                            w_state_next = DEAD;
                        end else begin
                            w_cnt_next = r_cnt - CNT_W'(1);
                        end
                    end
                end
                DEAD:    w_state_next = DEAD;
                default: w_state_next = IDLE;
            endcase
        end

        case (r_state)
            IDLE:    visible = 1'b1;
            FLASH:   visible = ~r_cnt[2];   // 4-frame on / 4-frame off blink
            default: visible = 1'b0;
        endcase
    end

endmodule

// File: rtl/sprite_compositor.sv
// Pipelined pixel compositor: maze, bullets, rotated tank sprites with
// palette transparency and hit-flash, title screen, background.
// Ports:
//   CLK, Reset             pixel clock, synchronous active-high reset
//   frame_start            one-cycle pulse per frame (drives flash timing)
//   DrawX, DrawY, blank    current pixel and active-video flag
//   title, maze            title-screen enable, maze-wall flag for this pixel
//   tank_x/y/dir/shot      per-tank centre, orientation and hit level
//   bul_x/y/s/active       per-bullet centre, half-size and valid
//   tank_rom_addr/q        registered sprite ROM address, ROM data back
//   title_addr/q           registered title ROM address, ROM data back
//   Red, Green, Blue       registered output colour, ROM_LAT+2 cycles after
//                          the pixel was presented
module sprite_compositor
    import sprite_pkg::*;
#(
    parameter int          NUM_TANKS       = 2,
    parameter int          NUM_BULLETS     = 3,
    parameter int          COORD_W         = 10,
    parameter int          SPRITE_DIM      = 20,
    parameter int          PAL_IDX_W       = 3,
    parameter int          ROM_LAT         = 1,
    parameter int          TRANSPARENT_IDX = 5,
    parameter int          FLASH_FRAMES    = 30,
    parameter logic [23:0] BG_RGB          = 24'h555555,
    localparam int         ADDR_W          = $clog2(SPRITE_DIM * SPRITE_DIM)
) (
    input  logic                             CLK,
    input  logic                             Reset,
    input  logic                             frame_start,
    input  logic [COORD_W-1:0]               DrawX,
    input  logic [COORD_W-1:0]               DrawY,
    input  logic                             blank,
    input  logic                             title,
    input  logic                             maze,
    input  logic [NUM_TANKS*COORD_W-1:0]     tank_x,
    input  logic [NUM_TANKS*COORD_W-1:0]     tank_y,
    input  logic [NUM_TANKS*2-1:0]           tank_dir,
    input  logic [NUM_TANKS-1:0]             tank_shot,
    input  logic [NUM_BULLETS*COORD_W-1:0]   bul_x,
    input  logic [NUM_BULLETS*COORD_W-1:0]   bul_y,
    input  logic [NUM_BULLETS*COORD_W-1:0]   bul_s,
    input  logic [NUM_BULLETS-1:0]           bul_active,
    output logic [NUM_TANKS*ADDR_W-1:0]      tank_rom_addr,
    input  logic [NUM_TANKS*PAL_IDX_W-1:0]   tank_rom_q,
    output logic [19:0]                      title_addr,
    input  logic [PAL_IDX_W-1:0]             title_q,
    output logic [7:0]                       Red,
    output logic [7:0]                       Green,
    output logic [7:0]                       Blue
);

    localparam int CW1  = COORD_W + 1;
    localparam int LX_W = $clog2(SPRITE_DIM);
    // Stage vector layout: {blank, title, maze, tank_on[NUM_TANKS], bul_hit[NUM_BULLETS]}
    localparam int SW   = 3 + NUM_TANKS + NUM_BULLETS;

    localparam logic signed [CW1-1:0] HALF_S = CW1'(SPRITE_DIM / 2);
    localparam logic signed [CW1-1:0] DIM_S  = CW1'(SPRITE_DIM);
    localparam logic [LX_W-1:0]       D_MAX  = LX_W'(SPRITE_DIM - 1);
    localparam logic [PAL_IDX_W-1:0]  TRANSP = PAL_IDX_W'(TRANSPARENT_IDX);

    logic [NUM_TANKS-1:0]   w_visible;
    logic [NUM_TANKS-1:0]   w_tank_on;
    logic [NUM_BULLETS-1:0] w_bul_hit;
    logic [ADDR_W-1:0]      w_addr [NUM_TANKS];
    logic [19:0]            w_title_addr;

    logic [SW-1:0]                r_stage [ROM_LAT+1];
    logic [NUM_TANKS*ADDR_W-1:0]  r_tank_addr;
    logic [19:0]                  r_title_addr;
    rgb_t                         r_rgb;

    // ---------------- tank hit test, rotation and flash ----------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_TANKS; gi++) begin : g_tank
            logic signed [CW1-1:0] w_dx, w_dy;
            logic                  w_hit;
            logic [LX_W-1:0]       w_lx, w_ly, w_sx, w_sy;
            dir_e                  w_dir;

            tank_flash_fsm #(
                .FLASH_FRAMES(FLASH_FRAMES)
            ) u_flash (
                .CLK        (CLK),
                .Reset      (Reset),
                .frame_start(frame_start),
                .tank_shot  (tank_shot[gi]),
                .visible    (w_visible[gi])
            );

            // One extra bit keeps sprites near x=0 from aliasing onto x~1023.
            assign w_dx = $signed({1'b0, DrawX}) - $signed({1'b0, tank_x[gi*COORD_W +: COORD_W]}) + HALF_S;
            assign w_dy = $signed({1'b0, DrawY}) - $signed({1'b0, tank_y[gi*COORD_W +: COORD_W]}) + HALF_S;

            assign w_hit = !w_dx[CW1-1] && (w_dx < DIM_S) && !w_dy[CW1-1] && (w_dy < DIM_S);
            assign w_lx  = w_dx[LX_W-1:0];
            assign w_ly  = w_dy[LX_W-1:0];
            assign w_dir = dir_e'(tank_dir[gi*2 +: 2]);

            // Map screen-local coordinates back to the unrotated sprite.
            always_comb begin
                w_sx = w_lx;
                w_sy = w_ly;
                case (w_dir)
                    DIR_90:  begin w_sx = w_ly;         w_sy = D_MAX - w_lx; end
                    DIR_180: begin w_sx = D_MAX - w_lx; w_sy = D_MAX - w_ly; end
                    DIR_270: begin w_sx = D_MAX - w_ly; w_sy = w_lx;         end
                    default: begin w_sx = w_lx;         w_sy = w_ly;         end
                endcase
            end

            assign w_addr[gi]    = w_hit ? (ADDR_W'(w_sy) * ADDR_W'(SPRITE_DIM) + ADDR_W'(w_sx)) : '0;
            assign w_tank_on[gi] = w_hit & w_visible[gi];
        end

        // ---------------- bullet hit test ----------------
        for (gi = 0; gi < NUM_BULLETS; gi++) begin : g_bul
            logic signed [CW1-1:0] w_bdx, w_bdy;
            logic [CW1-1:0]        w_adx, w_ady;

            assign w_bdx = $signed({1'b0, DrawX}) - $signed({1'b0, bul_x[gi*COORD_W +: COORD_W]});
            assign w_bdy = $signed({1'b0, DrawY}) - $signed({1'b0, bul_y[gi*COORD_W +: COORD_W]});
            assign w_adx = w_bdx[CW1-1] ? $unsigned(-w_bdx) : $unsigned(w_bdx);
            assign w_ady = w_bdy[CW1-1] ? $unsigned(-w_bdy) : $unsigned(w_bdy);

            assign w_bul_hit[gi] = bul_active[gi]
                                 && (w_adx <= {1'b0, bul_s[gi*COORD_W +: COORD_W]})
                                 && (w_ady <= {1'b0, bul_s[gi*COORD_W +: COORD_W]});
        end
    endgenerate

    assign w_title_addr = 20'(DrawX) + 20'(DrawY) * 20'd640;

    // ---------------- S0 and ROM-latency alignment stages ----------------
    always_ff @(posedge CLK) begin
        if (Reset) begin
            for (int i = 0; i <= ROM_LAT; i++) begin
                r_stage[i] <= '0;
            end
            r_tank_addr  <= '0;
            r_title_addr <= '0;
        end else begin
            r_stage[0] <= {blank, title, maze, w_tank_on, w_bul_hit};
            for (int i = 1; i <= ROM_LAT; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
            for (int t = 0; t < NUM_TANKS; t++) begin
                r_tank_addr[t*ADDR_W +: ADDR_W] <= w_addr[t];
            end
            r_title_addr <= w_title_addr;
        end
    end

    assign tank_rom_addr = r_tank_addr;
    assign title_addr    = r_title_addr;

    // ---------------- final stage: priority mux and palette ----------------
    logic [SW-1:0]          w_fin;
    logic                   w_fin_blank, w_fin_title, w_fin_maze;
    logic [NUM_TANKS-1:0]   w_fin_tank;
    logic [NUM_BULLETS-1:0] w_fin_bul;
    logic [PAL_IDX_W-1:0]   w_q;
    rgb_t                   w_rgb;

    assign w_fin       = r_stage[ROM_LAT];
    assign w_fin_blank = w_fin[SW-1];
    assign w_fin_title = w_fin[SW-2];
    assign w_fin_maze  = w_fin[SW-3];
    assign w_fin_tank  = w_fin[NUM_BULLETS +: NUM_TANKS];
    assign w_fin_bul   = w_fin[NUM_BULLETS-1:0];

    // Layers are applied lowest priority first so later assignments win.
    always_comb begin
        w_rgb = BG_RGB;
        w_q   = '0;
        for (int t = NUM_TANKS - 1; t >= 0; t--) begin
            w_q = tank_rom_q[t*PAL_IDX_W +: PAL_IDX_W];
            if (w_fin_tank[t] && (w_q != TRANSP)) begin
                w_rgb = pal_lookup(pal_idx_t'(w_q));
            end
        end
        for (int b = NUM_BULLETS - 1; b >= 0; b--) begin
            if (w_fin_bul[b]) begin
                w_rgb = RGB_BLACK;
            end
        end
        if (w_fin_maze) begin
            w_rgb = RGB_BLACK;
        end
        if (w_fin_title) begin
            w_rgb = pal_lookup(pal_idx_t'(title_q));
        end
        if (!w_fin_blank) begin
            w_rgb = RGB_BLACK;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_rgb <= RGB_BLACK;
        end else begin
            r_rgb <= w_rgb;
        end
    end

    assign Red   = r_rgb[23:16];
    assign Green = r_rgb[15:8];
    assign Blue  = r_rgb[7:0];

endmodule

// File: tb/tb_sprite_compositor.sv
// Self-checking bench for sprite_compositor: reset/refill, a directed vector
// table, mid-frame reset, the hit-flash sequence and randomized pixels
// checked against a behavioural model.
module tb_sprite_compositor;

    localparam int NT   = 2;
    localparam int NB   = 3;
    localparam int CW   = 10;
    localparam int AW   = 9;
    localparam int ROM_LAT = 1;
    localparam int LAT  = ROM_LAT + 2;
    localparam logic [23:0] BG = 24'h555555;
    localparam logic [23:0] PAL [8] = '{
        24'hFF3131, 24'h312D2B, 24'h878685, 24'h9B9DA0,
        24'hFFE100, 24'hFF00D6, 24'h000000, 24'hFFFFFF
    };

    logic CLK = 1'b0;
    logic Reset;
    logic frame_start;
    logic [CW-1:0] DrawX, DrawY;
    logic blank, title, maze;
    logic [NT*CW-1:0] tank_x, tank_y;
    logic [NT*2-1:0]  tank_dir;
    logic [NT-1:0]    tank_shot;
    logic [NB*CW-1:0] bul_x, bul_y, bul_s;
    logic [NB-1:0]    bul_active;
    logic [NT*AW-1:0] tank_rom_addr;
    logic [NT*3-1:0]  tank_rom_q;
    logic [19:0]      title_addr;
    logic [2:0]       title_q;
    logic [7:0]       Red, Green, Blue;

    // Bench-side stimulus state
    int px, py;
    bit blk, tit, maz, fs;
    int tx [NT], ty [NT], td [NT], fill [NT];
    bit shot [NT];
    int bx [NB], by [NB], bs [NB];
    bit ba [NB];
    bit fill_mode, tfill_mode;
    int tfill;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    sprite_compositor dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .frame_start  (frame_start),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .blank        (blank),
        .title        (title),
        .maze         (maze),
        .tank_x       (tank_x),
        .tank_y       (tank_y),
        .tank_dir     (tank_dir),
        .tank_shot    (tank_shot),
        .bul_x        (bul_x),
        .bul_y        (bul_y),
        .bul_s        (bul_s),
        .bul_active   (bul_active),
        .tank_rom_addr(tank_rom_addr),
        .tank_rom_q   (tank_rom_q),
        .title_addr   (title_addr),
        .title_q      (title_q),
        .Red          (Red),
        .Green        (Green),
        .Blue         (Blue)
    );

    always_comb begin
        DrawX = 10'(px);
        DrawY = 10'(py);
        blank = blk;
        title = tit;
        maze  = maz;
        frame_start = fs;
        tank_x = '0; tank_y = '0; tank_dir = '0; tank_shot = '0;
        bul_x = '0; bul_y = '0; bul_s = '0; bul_active = '0;
        for (int t = 0; t < NT; t++) begin
            tank_x[t*CW +: CW] = 10'(tx[t]);
            tank_y[t*CW +: CW] = 10'(ty[t]);
            tank_dir[t*2 +: 2] = 2'(td[t]);
            tank_shot[t]       = shot[t];
        end
        for (int b = 0; b < NB; b++) begin
            bul_x[b*CW +: CW] = 10'(bx[b]);
            bul_y[b*CW +: CW] = 10'(by[b]);
            bul_s[b*CW +: CW] = 10'(bs[b]);
            bul_active[b]     = ba[b];
        end
    end

    // ROM contents: either a constant fill per tank or an address pattern.
    function automatic logic [2:0] trom(int t, int a);
        if (fill_mode) return 3'(fill[t]);
        return 3'((a * 3 + t * 5) % 8);
    endfunction

    function automatic logic [2:0] titrom(int a);
        if (tfill_mode) return 3'(tfill);
        return 3'((a ^ (a >> 4)) % 8);
    endfunction

    logic [NT*3-1:0] tq_pipe [ROM_LAT];
    logic [2:0]      ttq_pipe [ROM_LAT];

    always @(posedge CLK) begin
        for (int t = 0; t < NT; t++) begin
            tq_pipe[0][t*3 +: 3] <= trom(t, int'(tank_rom_addr[t*AW +: AW]));
        end
        ttq_pipe[0] <= titrom(int'(title_addr));
        for (int i = 1; i < ROM_LAT; i++) begin
            tq_pipe[i]  <= tq_pipe[i-1];
            ttq_pipe[i] <= ttq_pipe[i-1];
        end
    end
    assign tank_rom_q = tq_pipe[ROM_LAT-1];
    assign title_q    = ttq_pipe[ROM_LAT-1];

    function automatic int iabs(int v);
        return (v < 0) ? -v : v;
    endfunction

    // Behavioural reference: layered painter's rules on plain integers.
    function automatic logic [23:0] model_rgb();
        int lx, ly, sx, sy;
        logic [2:0] q;
        if (!blk) return 24'h0;
        if (tit)  return PAL[titrom(px + py * 640)];
        if (maz)  return 24'h0;
        for (int b = 0; b < NB; b++)
            if (ba[b] && iabs(px - bx[b]) <= bs[b] && iabs(py - by[b]) <= bs[b]) return 24'h0;
        for (int t = 0; t < NT; t++) begin
            lx = px - tx[t] + 10;
            ly = py - ty[t] + 10;
            if (lx >= 0 && lx < 20 && ly >= 0 && ly < 20) begin
                case (td[t])
                    0:       begin sx = lx;      sy = ly;      end
                    1:       begin sx = ly;      sy = 19 - lx; end
                    2:       begin sx = 19 - lx; sy = 19 - ly; end
                    default: begin sx = 19 - ly; sy = lx;      end
                endcase
                q = trom(t, sy * 20 + sx);
                if (q != 3'd5) return PAL[q];
            end
        end
        return BG;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] rgb_out();
        return {Red, Green, Blue};
    endfunction

    typedef struct {
        string name;
        int x, y;
        bit blank, title, maze;
        int tq;
        int t0x, t0y, t0d, f0;
        int t1x, t1y, f1;
        int bx, by, bs;
        bit ba;
        int exp_addr0;
        logic [23:0] exp_rgb;
    } vec_t;

    vec_t vecs [$];

    task automatic add(input string n, input int x, input int y, input bit bl, input bit ti,
                       input bit mz, input int tq, input int t0x, input int t0y, input int t0d,
                       input int f0, input int t1x, input int t1y, input int f1, input int vbx,
                       input int vby, input int vbs, input bit vba, input int ea,
                       input logic [23:0] er);
        vec_t v;
        v.name = n; v.x = x; v.y = y; v.blank = bl; v.title = ti; v.maze = mz; v.tq = tq;
        v.t0x = t0x; v.t0y = t0y; v.t0d = t0d; v.f0 = f0;
        v.t1x = t1x; v.t1y = t1y; v.f1 = f1;
        v.bx = vbx; v.by = vby; v.bs = vbs; v.ba = vba;
        v.exp_addr0 = ea; v.exp_rgb = er;
        vecs.push_back(v);
    endtask

    task automatic clear_scene();
        px = 300; py = 200; blk = 1; tit = 0; maz = 0; fs = 0;
        for (int t = 0; t < NT; t++) begin
            tx[t] = 600 + t * 100; ty[t] = 400; td[t] = 0; fill[t] = 0; shot[t] = 0;
        end
        for (int b = 0; b < NB; b++) begin
            bx[b] = 0; by[b] = 0; bs[b] = 0; ba[b] = 0;
        end
        fill_mode = 1; tfill_mode = 1; tfill = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] e;
        logic [23:0] expq [$];
        bit exp_vis;

        // ---------------- reset and pipeline refill ----------------
        clear_scene();
        Reset = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("reset_rgb", 32'(rgb_out()), 32'h0);
            check("reset_taddr", 32'(title_addr), 32'h0);
            check("reset_addr", 32'(tank_rom_addr), 32'h0);
        end
        Reset = 0;
        for (int i = 0; i < LAT; i++) begin
            @(negedge CLK);
            check("refill_rgb", 32'(rgb_out()), (i == LAT - 1) ? 32'(BG) : 32'h0);
        end
        $display("reset/refill done rgb=%h", rgb_out());

        // ---------------- directed vector table ----------------
        //   name        x    y  bl ti mz tq  t0x t0y d f0  t1x t1y f1  bx by bs ba  addr0 rgb
        add("dir0",      90,  90, 1, 0, 0, 0, 100,100,0,1, 600,400,0,  0, 0,0, 0,   0, 24'h312D2B);
        add("dir180",    90,  90, 1, 0, 0, 0, 100,100,2,1, 600,400,0,  0, 0,0, 0, 399, 24'h312D2B);
        add("dir90",     90,  90, 1, 0, 0, 0, 100,100,1,2, 600,400,0,  0, 0,0, 0, 380, 24'h878685);
        add("dir270",    90,  90, 1, 0, 0, 0, 100,100,3,3, 600,400,0,  0, 0,0, 0,  19, 24'h9B9DA0);
        add("transp",    90,  90, 1, 0, 0, 0, 100,100,0,5, 600,400,0,  0, 0,0, 0,   0, 24'h555555);
        add("edge_in",  109, 109, 1, 0, 0, 0, 100,100,0,4, 600,400,0,  0, 0,0, 0, 399, 24'hFFE100);
        add("edge_outx",110, 109, 1, 0, 0, 0, 100,100,0,4, 600,400,0,  0, 0,0, 0,   0, 24'h555555);
        add("edge_outy",109, 110, 1, 0, 0, 0, 100,100,0,4, 600,400,0,  0, 0,0, 0,   0, 24'h555555);
        add("tank_pri", 100, 100, 1, 0, 0, 0, 100,100,0,2, 105,105,3,  0, 0,0, 0, 210, 24'h878685);
        add("tank_fall",100, 100, 1, 0, 0, 0, 100,100,0,5, 105,105,3,  0, 0,0, 0, 210, 24'h9B9DA0);
        add("bul_win",   50,  50, 1, 0, 0, 0, 300,300,0,1,  51, 51,0, 50,50,2, 1,   0, 24'h000000);
        add("bul_off",   50,  50, 1, 0, 0, 0, 300,300,0,1,  51, 51,0, 50,50,2, 0,   0, 24'hFF3131);
        add("bul_edge",  52,  48, 1, 0, 0, 0, 300,300,0,1,  51, 51,0, 50,50,2, 1,   0, 24'h000000);
        add("bul_out",   53,  50, 1, 0, 0, 0, 300,300,0,1,  51, 51,0, 50,50,2, 1,   0, 24'hFF3131);
        add("title",    639, 479, 1, 1, 0, 4, 100,100,0,1, 600,400,0,  0, 0,0, 0,   0, 24'hFFE100);
        add("blank",    639, 479, 0, 1, 0, 4, 100,100,0,1, 600,400,0,  0, 0,0, 0,   0, 24'h000000);
        add("maze",      91,  90, 1, 0, 1, 0, 100,100,0,1, 600,400,0,  0, 0,0, 0,   1, 24'h000000);
        add("offscr",     0,  95, 1, 0, 0, 0,   5,100,0,7, 600,400,0,  0, 0,0, 0, 105, 24'hFFFFFF);
        add("nowrap",  1019,  95, 1, 0, 0, 0,   5,100,0,7, 600,400,0,  0, 0,0, 0,   0, 24'h555555);
        add("nowrap2", 1015,  95, 1, 0, 0, 0,   5,100,0,7, 600,400,0,  0, 0,0, 0,   0, 24'h555555);

        foreach (vecs[i]) begin
            px = vecs[i].x; py = vecs[i].y;
            blk = vecs[i].blank; tit = vecs[i].title; maz = vecs[i].maze;
            tfill = vecs[i].tq;
            tx[0] = vecs[i].t0x; ty[0] = vecs[i].t0y; td[0] = vecs[i].t0d; fill[0] = vecs[i].f0;
            tx[1] = vecs[i].t1x; ty[1] = vecs[i].t1y; td[1] = 0;           fill[1] = vecs[i].f1;
            bx[0] = vecs[i].bx; by[0] = vecs[i].by; bs[0] = vecs[i].bs; ba[0] = vecs[i].ba;
            @(negedge CLK);
            check({vecs[i].name, "_addr0"}, 32'(tank_rom_addr[AW-1:0]), 32'(vecs[i].exp_addr0));
            check({vecs[i].name, "_taddr"}, 32'(title_addr), 32'(vecs[i].x + vecs[i].y * 640));
            repeat (LAT - 1) @(negedge CLK);
            check({vecs[i].name, "_rgb"}, 32'(rgb_out()), 32'(vecs[i].exp_rgb));
            $display("vec %s addr0=%0d taddr=%0d rgb=%h", vecs[i].name,
                     tank_rom_addr[AW-1:0], title_addr, rgb_out());
        end

        // ---------------- reset in the middle of a frame ----------------
        clear_scene();
        px = 90; py = 90; tx[0] = 100; ty[0] = 100; fill[0] = 1;
        repeat (LAT + 1) @(negedge CLK);
        check("mid_pre", 32'(rgb_out()), 32'h312D2B);
        Reset = 1;
        @(negedge CLK);
        check("mid_reset", 32'(rgb_out()), 32'h0);
        Reset = 0;
        for (int i = 0; i < LAT; i++) begin
            @(negedge CLK);
            check("mid_refill", 32'(rgb_out()), (i == LAT - 1) ? 32'h312D2B : 32'h0);
        end
        $display("mid-frame reset done rgb=%h", rgb_out());

        // ---------------- hit-flash sequence ----------------
        clear_scene();
        px = 100; py = 100; tx[0] = 100; ty[0] = 100; fill[0] = 1;
        repeat (LAT + 1) @(negedge CLK);
        check("flash_idle", 32'(rgb_out()), 32'h312D2B);
        // Rising shot coincides with frame_start: counter must load, not decrement.
        shot[0] = 1; fs = 1;
        @(negedge CLK);
        fs = 0;
        for (int n = 0; n <= 32; n++) begin
            if (n > 0) begin
                fs = 1;
                @(negedge CLK);
                fs = 0;
            end
            repeat (LAT + 1) @(negedge CLK);
            exp_vis = (n < 30) && (((30 - n) & 4) == 0);
            check($sformatf("flash_n%0d", n), 32'(rgb_out()), exp_vis ? 32'h312D2B : 32'(BG));
            $display("flash pulses=%0d rgb=%h", n, rgb_out());
        end
        shot[0] = 0;
        repeat (LAT) @(negedge CLK);
        check("respawn_early", 32'(rgb_out()), 32'(BG));
        @(negedge CLK);
        check("respawn", 32'(rgb_out()), 32'h312D2B);
        $display("respawn rgb=%h", rgb_out());

        // ---------------- randomized pixels vs. model ----------------
        clear_scene();
        fill_mode = 0; tfill_mode = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK);
            if (expq.size() == LAT) begin
                e = expq.pop_front();
                check("rand_rgb", 32'(rgb_out()), 32'(e));
            end
            px  = int'($urandom_range(0, 1023));
            py  = int'($urandom_range(0, 1023));
            blk = ($urandom_range(0, 7) != 0);
            tit = ($urandom_range(0, 7) == 0);
            maz = ($urandom_range(0, 7) == 0);
            for (int t = 0; t < NT; t++) begin
                tx[t] = px + int'($urandom_range(0, 26)) - 13;
                ty[t] = py + int'($urandom_range(0, 26)) - 13;
                if (tx[t] < 0) tx[t] = 0;
                if (ty[t] < 0) ty[t] = 0;
                if (tx[t] > 1023) tx[t] = 1023;
                if (ty[t] > 1023) ty[t] = 1023;
                td[t] = int'($urandom_range(0, 3));
            end
            for (int b = 0; b < NB; b++) begin
                bx[b] = px + int'($urandom_range(0, 8)) - 4;
                by[b] = py + int'($urandom_range(0, 8)) - 4;
                if (bx[b] < 0) bx[b] = 0;
                if (by[b] < 0) by[b] = 0;
                if (bx[b] > 1023) bx[b] = 1023;
                if (by[b] > 1023) by[b] = 1023;
                bs[b] = int'($urandom_range(0, 3));
                ba[b] = ($urandom_range(0, 3) == 0);
            end
            expq.push_back(model_rgb());
        end
        $display("random phase done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
